// File: rtl/div64_seq.sv
// div64_seq: sequential 64-bit unsigned restoring divider.
// Produces one quotient bit per clock. Each trial subtraction is done as
// a + ~b + 1 on a 64-bit carry-lookahead adder (cla64 below).
// Optional feature: define DIV64_SEQ_EARLY_EXIT_EN to finish in one cycle
// when dividend < divisor. Without it, every nonzero-divisor operation
// takes exactly 64 cycles.
`timescale 1ns/1ps

module div64_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [63:0] quotient,
  output logic [63:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZERO = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // cla64: two-level carry-lookahead adder. Bits are grouped in fours,
  // groups in fours again, and carries are resolved top-down.
  // ---------------------------------------------------------------------

  // Carries into positions 1..3 of a 4-wide lookahead block.
  function automatic logic [2:0] la3(input logic [3:0] g, input logic [3:0] p,
                                     input logic c0);
    logic [2:0] c;
    c[0] = g[0] | (p[0] & c0);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // Group generate of a 4-wide lookahead block.
  function automatic logic grp_g(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Returns {carry_out, sum}.
  function automatic logic [64:0] cla64(input logic [63:0] a, input logic [63:0] b,
                                        input logic cin);
    logic [63:0] g, p, c;
    logic [15:0] g1, p1, c1;
    logic [3:0]  g2, p2, c2;
    logic        cout;
    g = a & b;
    p = a ^ b;
    for (int k = 0; k < 16; k++) begin
      g1[k] = grp_g(g[4*k +: 4], p[4*k +: 4]);
      p1[k] = &p[4*k +: 4];
    end
    for (int j = 0; j < 4; j++) begin
      g2[j] = grp_g(g1[4*j +: 4], p1[4*j +: 4]);
      p2[j] = &p1[4*j +: 4];
    end
    c2   = {la3(g2, p2, cin), cin};
    cout = grp_g(g2, p2) | (&p2 & cin);
    for (int j = 0; j < 4; j++) begin
      c1[4*j +: 4] = {la3(g1[4*j +: 4], p1[4*j +: 4], c2[j]), c2[j]};
    end
    for (int k = 0; k < 16; k++) begin
      c[4*k +: 4] = {la3(g[4*k +: 4], p[4*k +: 4], c1[k]), c1[k]};
    end
    return {cout, p ^ c};
  endfunction

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_t      r_state;
  state_t      w_next_state;

  logic [63:0] r_q;          // shifting dividend / quotient register
  logic [63:0] r_d;          // captured divisor
  // The partial remainder is always < divisor after each step, so 64 bits
  // hold it; the 65th bit only exists transiently in w_t.
  logic [63:0] r_r;
  logic [5:0]  r_cnt;
  logic        r_dz_path;    // one-cycle path taken because divisor was 0

  logic        r_done;
  logic [63:0] r_quotient;
  logic [63:0] r_remainder;
  logic        r_div_by_zero;

  // Control decoded from state
  logic        w_busy;
  logic        w_capture;
  logic        w_step;
  logic        w_fin_run;
  logic        w_fin_zero;

  // One restoring-division step
  logic [64:0] w_t;
  logic [64:0] w_sub;
  logic [63:0] w_diff;
  logic        w_carry;
  logic        w_qbit;
  logic [63:0] w_r_next;
  logic [63:0] w_q_next;
  logic        w_last;
  logic        w_short;

  assign w_t      = {r_r, r_q[63]};
  assign w_sub    = cla64(w_t[63:0], ~r_d, 1'b1);
  assign w_diff   = w_sub[63:0];
  assign w_carry  = w_sub[64];
  // Subtract when the shifted-out bit is set (t certainly exceeds d) or
  // when t[63:0] - d does not borrow.
  assign w_qbit   = w_t[64] | w_carry;
  assign w_r_next = w_qbit ? w_diff : w_t[63:0];
  assign w_q_next = {r_q[62:0], w_qbit};
  assign w_last   = (r_cnt == 6'd63);

`ifdef DIV64_SEQ_EARLY_EXIT_EN
  assign w_short  = (divisor == 64'd0) || (dividend < divisor);
`else
  assign w_short  = (divisor == 64'd0);
`endif

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned (which would infer a latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = w_short ? S_ZERO : S_RUN;
      S_RUN:   if (w_last) w_next_state = S_IDLE;
      S_ZERO:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Control outputs decoded from the current state
  always_comb begin
    w_busy     = 1'b0;
    w_capture  = 1'b0;
    w_step     = 1'b0;
    w_fin_run  = 1'b0;
    w_fin_zero = 1'b0;
    case (r_state)
      S_IDLE: w_capture = start;
      S_RUN: begin
        w_busy    = 1'b1;
        w_step    = 1'b1;
        w_fin_run = w_last;
      end
      S_ZERO: begin
        w_busy     = 1'b1;
        w_fin_zero = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand capture and one quotient bit per RUN cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q       <= 64'd0;
      r_d       <= 64'd0;
      r_r       <= 64'd0;
      r_cnt     <= 6'd0;
      r_dz_path <= 1'b0;
    end else if (w_capture) begin
      r_q       <= dividend;
      r_d       <= divisor;
      r_r       <= 64'd0;
      r_cnt     <= 6'd0;
      r_dz_path <= (divisor == 64'd0);
    end else if (w_step) begin
      r_q       <= w_q_next;
      r_r       <= w_r_next;
      r_cnt     <= r_cnt + 6'd1;
    end
  end

  // Result registers: written only on completion, held otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done        <= 1'b0;
      r_quotient    <= 64'd0;
      r_remainder   <= 64'd0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= w_fin_run | w_fin_zero;
      if (w_fin_run) begin
        r_quotient    <= w_q_next;
        r_remainder   <= w_r_next;
        r_div_by_zero <= 1'b0;
      end else if (w_fin_zero) begin
        // Divide-by-zero saturates the quotient; the early-exit path
        // (dividend < divisor) yields a zero quotient.
        r_quotient    <= {64{r_dz_path}};
        r_remainder   <= r_q;
        r_div_by_zero <= r_dz_path;
      end
    end
  end

  assign busy        = w_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_div64_seq.sv
// tb_div64_seq: self-checking bench for div64_seq.
// A cycle-level behavioural model (plain / and % with a latency countdown)
// is compared against the DUT outputs on every falling edge; directed
// operations additionally pin hand-computed results and latencies.
`timescale 1ns/1ps

module tb_div64_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] dividend = 64'd0;
  logic [63:0] divisor = 64'd0;
  logic        busy;
  logic        done;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef DIV64_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int SHORT_LAT = EARLY ? 1 : 64;

  div64_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_dz   = 1'b0;
  logic [63:0] m_q = 64'd0;
  logic [63:0] m_r = 64'd0;
  logic [63:0] m_a = 64'd0;
  logic [63:0] m_b = 64'd0;
  int          m_left = 0;

  function automatic int exp_latency(input logic [63:0] a, input logic [63:0] b);
    if (b == 64'd0) return 1;
    if (EARLY && (a < b)) return 1;
    return 64;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_q = 64'd0; m_r = 64'd0; m_a = 64'd0; m_b = 64'd0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          if (m_b == 64'd0) begin
            m_q = '1; m_r = m_a; m_dz = 1'b1;
          end else begin
            m_q = m_a / m_b; m_r = m_a % m_b; m_dz = 1'b0;
          end
        end
      end else if (start) begin
        m_a = dividend;
        m_b = divisor;
        m_left = exp_latency(dividend, divisor);
        m_busy = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [127:0] recon;
  always @(negedge clk) begin
    check("busy", 64'(busy), 64'(m_busy));
    check("done", 64'(done), 64'(m_done));
    check("quotient", quotient, m_q);
    check("remainder", remainder, m_r);
    check("div_by_zero", 64'(div_by_zero), 64'(m_dz));
    if (done && m_done && !m_dz) begin
      recon = 128'(quotient) * 128'(m_b) + 128'(remainder);
      check("invariant_recon", 64'(recon == 128'(m_a)), 64'd1);
      check("invariant_rem_lt_div", 64'(remainder < m_b), 64'd1);
    end
  end

  // ---------------- directed operation ----------------
  task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] eq, input logic [63:0] er, input logic edz,
                        input int elat);
    int lat;
    bit seen;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = ~a;            // operands matter only at the accepting edge
    divisor  = b ^ 64'h5;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({name, " done_seen"}, 64'(seen), 64'd1);
    check({name, " latency"}, 64'(lat), 64'(elat));
    check({name, " quotient"}, quotient, eq);
    check({name, " remainder"}, remainder, er);
    check({name, " div_by_zero"}, 64'(div_by_zero), 64'(edz));
    check({name, " busy_at_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    int pulses;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset quotient", quotient, 64'd0);
    check("reset remainder", remainder, 64'd0);
    check("reset div_by_zero", 64'(div_by_zero), 64'd0);
    reset = 1'b0;

    // 10! / 10 = 9!
    run_op("fact10", 64'd3628800, 64'd10, 64'd362880, 64'd0, 1'b0, 64);

    // Reset mid-RUN: 100/7 aborted at cycle 30
    @(negedge clk);
    dividend = 64'd100; divisor = 64'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset quotient", quotient, 64'd0);
    check("midreset remainder", remainder, 64'd0);
    check("midreset div_by_zero", 64'(div_by_zero), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midreset no_done_pulse", 64'(pulses), 64'd0);
    run_op("after_reset_100_7", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 64);

    // t[64] path
    run_op("t64_path", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
           64'd1, 64'h7FFF_FFFF_FFFF_FFFE, 1'b0, 64);

    // Divide by zero, then a normal operation clears div_by_zero
    run_op("div_zero_55", 64'd55, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd55, 1'b1, 1);
    run_op("div_55_5", 64'd55, 64'd5, 64'd11, 64'd0, 1'b0, 64);

    // dividend < divisor (early-exit candidate)
    run_op("small_5_9", 64'd5, 64'd9, 64'd0, 64'd5, 1'b0, SHORT_LAT);
    run_op("zero_over_1", 64'd0, 64'd1, 64'd0, 64'd0, 1'b0, SHORT_LAT);
    run_op("max_over_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 64);
    run_op("max_over_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 64);

    // start held high; operands changed at cycle 10; back-to-back restart
    @(negedge clk);
    dividend = 64'd1000; divisor = 64'd3; start = 1'b1;
    @(posedge clk);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk); lat++;
      if (lat == 10) begin
        #1;
        dividend = 64'd77; divisor = 64'd8;
      end
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("held first done_seen", 64'(seen), 64'd1);
    check("held first latency", 64'(lat), 64'd64);
    check("held first quotient", quotient, 64'd333);
    check("held first remainder", remainder, 64'd1);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("held second done_seen", 64'(seen), 64'd1);
    check("held second spacing", 64'(lat), 64'd65);
    check("held second quotient", quotient, 64'd9);
    check("held second remainder", remainder, 64'd5);
    check("held second div_by_zero", 64'(div_by_zero), 64'd0);

    // Results hold while idle
    repeat (5) @(negedge clk);
    check("hold quotient", quotient, 64'd9);
    check("hold remainder", remainder, 64'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
